mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single-port page memory among three requesters: host loader (0), parity/XOR engine (1) and output drain (2). Sits between the requesters and the memory macro; muxes address, write data and enables from the current owner; returns shared read data with a per-requester valid. Supports single accesses and locked bursts, with a hold limit so no requester starves.

## Interface
- `ADR_W`, 3: page address width.
- `DATA_W`, 8: data word width.
- `MAX_HOLD`, 8: maximum consecutive cycles a locked owner keeps the grant while others wait; must be at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `req`  in  3  per-requester access request.
- `lock`  in  3  per-requester burst hold; meaningful only with `req`.
- `we`  in  3  per-requester write (1) / read (0).
- `adr`  in  3*ADR_W  packed addresses; requester i in bits [i*ADR_W +: ADR_W].
- `wdata`  in  3*DATA_W  packed write data, same packing.
- `gnt`  out  3  registered one-hot grant.
- `rvalid`  out  3  one-hot; read data valid for the requester granted a read in the previous cycle.
- `rdata`  out  DATA_W  equals `mem_rdata`.
- `preempt`  out  1  one-cycle pulse when a locked owner is forcibly released.
- `busy`  out  1  high while any `gnt` bit is set.
- `mem_adr`  out  ADR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable.
- `mem_rdata`  in  DATA_W  memory read data; one-cycle latency.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWNED: exactly one `gnt` bit set.
- IDLE -> OWNED: at an edge where `req != 0`. The winner's `gnt` bit is set at that edge.
- Memory access: each cycle `gnt[i]` is high, requester i's `adr`, `wdata` and `we` drive the memory combinationally.
  - `mem_we = req[i] & we[i]`.
  - `mem_re = req[i] & ~we[i]`.
  - If `req[i]` is low, both enables are 0 and no access occurs.
- Release rules while OWNED by i, evaluated at each edge:
  - `req[i] & lock[i]` low: release.
  - Hold counter equals MAX_HOLD-1 and another `req` bit is high: forced release, and `preempt` pulses for the following cycle.
  - Otherwise the owner keeps the grant and the hold counter increments.
- On release:
  - If other requests are pending, the new winner is chosen and granted at the same edge, with no idle cycle.
  - Otherwise the FSM returns to IDLE.
- Hold counter:
  - clog2(MAX_HOLD) bits.
  - Cleared on every new grant.
  - Saturates at MAX_HOLD-1 when nobody else is waiting, so the owner continues.
- `rvalid[i]` is the registered value of `gnt[i] & req[i] & ~we[i]`.
- `busy = |gnt`.

## Timing
- Reset values:
  - `gnt`, `rvalid`, `preempt`, `busy`, `mem_we`, `mem_re`, hold counter: 0.
  - `mem_adr`, `mem_wdata`: 0.
  - FSM: IDLE.
  - Round-robin pointer: "last owner = 2".
- Latency:
  - `req` sampled in cycle n (IDLE) -> `gnt` high in n+1.
  - A read performed in n+1 -> `rvalid` high and data on `rdata` in n+2.
- Single access (`lock` low): `gnt` lasts exactly one cycle.
- Back-to-back single accesses by one requester with no competition: `gnt` stays high every cycle (re-granted at each edge).
- Reset mid-burst: `gnt` drops at the reset edge; any `rvalid` due next cycle is suppressed.
- Simultaneous requests from all three in IDLE: resolved by the policy in Configuration.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin policy; a 2-bit last-owner pointer updates on every grant.
  - Priority order starts at last owner + 1 (mod 3).
  - A releasing requester cannot win again while another `req` bit is high.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority 0 > 1 > 2; no pointer register.
  - A releasing requester may win again immediately.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `NUM_REQ = 3`.
  - Requester indices `REQ_HOST = 0`, `REQ_ENGINE = 1`, `REQ_DRAIN = 2`.
  - FSM state encoding (IDLE, OWNED).
- Sub-module `arb_picker`: combinational request vector + pointer (pointer ignored when the macro is undefined) -> one-hot winner.
- The top holds the FSM, hold counter, pointer, `rvalid` register and memory muxing.

## Test plan
- Reset, then `req=3'b010`, `we[1]=0`, `adr[1]=5` for one cycle -> `gnt=3'b010` next cycle with `mem_re=1`, `mem_adr=5`; `rvalid=3'b010` the cycle after, `rdata=mem_rdata`.
- `req=3'b111` held, no locks -> fixed mode: `gnt` stays 001. RR mode: `gnt` cycles 001, 010, 100, 001.
- Requester 2 locks a 4-word write burst with no competition -> `gnt=3'b100` for 4 consecutive cycles; `mem_we=1` each cycle; `mem_adr` follows `adr[2]`.
- Requester 0 locks indefinitely, requester 1 requests, MAX_HOLD=8 -> `gnt[0]` high for exactly 8 cycles; `preempt` pulses once; `gnt=3'b010` in the following cycle.
- `gnt[1]` high on a read, `req[1]` dropped in the same cycle -> `mem_re=0` and no `rvalid` next cycle.
- `rst` asserted during a locked read burst -> next cycle `gnt=0`, `rvalid=0`, `busy=0`; a request after reset is granted with one-cycle latency.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the page-memory arbiter: requester indices, FSM states
// and a one-hot to index helper.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned REQ_HOST   = 0;
  localparam int unsigned REQ_ENGINE = 1;
  localparam int unsigned REQ_DRAIN  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of mem_arbiter; the arbiter uses the
// slave modport, requesters and the memory model use the master modport.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADR_W  = 3,
  parameter int unsigned DATA_W = 8
) ();

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADR_W-1:0]  adr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      preempt;
  logic                      busy;
  logic [ADR_W-1:0]          mem_adr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic                      mem_re;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, lock, we, adr, wdata, mem_rdata,
    output gnt, rvalid, rdata, preempt, busy, mem_adr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output req, lock, we, adr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, preempt, busy, mem_adr, mem_wdata, mem_we, mem_re
  );

endinterface

// File: rtl/arb_picker.sv
// Combinational winner selection. MEM_ARB_RR_EN selects round-robin starting
// after the last owner; otherwise fixed priority host > engine > drain.
module arb_picker
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] win
);

`ifdef MEM_ARB_RR_EN
  logic [1:0] cand;
  logic       found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((32'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        win[cand] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win = '0;
    if (req[REQ_HOST])        win[REQ_HOST]   = 1'b1;
    else if (req[REQ_ENGINE]) win[REQ_ENGINE] = 1'b1;
    else if (req[REQ_DRAIN])  win[REQ_DRAIN]  = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port page memory arbiter for host, XOR engine and drain with locked
// bursts and a hold limit. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADR_W    = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned          HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          state, state_n;
  logic [NUM_REQ-1:0]  gnt_q, gnt_n;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [HOLD_W-1:0]   hold_q, hold_n;
  logic                preempt_q, preempt_n;
  logic                new_grant;
  logic [1:0]          ptr_q;
  logic [NUM_REQ-1:0]  others, cand, win;
  logic                keep, at_limit;

  assign others   = bus.req & ~gnt_q;
  assign keep     = |(gnt_q & bus.req & bus.lock);
  assign at_limit = (hold_q == HOLD_MAX);
  // On a forced release the owner is excluded so fixed priority cannot hand it back.
  assign cand     = (state == OWNED && keep) ? others : bus.req;

  arb_picker u_picker (
    .req (cand),
    .ptr (ptr_q),
    .win (win)
  );

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    hold_n    = hold_q;
    preempt_n = 1'b0;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_n   = OWNED;
          gnt_n     = win;
          hold_n    = '0;
          new_grant = 1'b1;
        end
      end
      OWNED: begin
        if (!keep) begin
          hold_n = '0;
          if (|bus.req) begin
            gnt_n     = win;
            new_grant = 1'b1;
          end else begin
            gnt_n   = '0;
            state_n = IDLE;
          end
        end else if (at_limit && |others) begin
          gnt_n     = win;
          hold_n    = '0;
          preempt_n = 1'b1;
          new_grant = 1'b1;
        end else if (!at_limit) begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
      rvalid_q  <= '0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      hold_q    <= hold_n;
      preempt_q <= preempt_n;
      rvalid_q  <= gnt_q & bus.req & ~bus.we;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd2;
    else if (new_grant) ptr_q <= onehot_idx(gnt_n);
  end
`else
  logic unused_grant;
  assign unused_grant = new_grant;
  assign ptr_q        = 2'd2;
`endif

  logic [ADR_W-1:0]  mux_adr;
  logic [DATA_W-1:0] mux_wdata;

  always_comb begin
    mux_adr   = '0;
    mux_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        mux_adr   = bus.adr[i*ADR_W +: ADR_W];
        mux_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.mem_adr   = mux_adr;
  assign bus.mem_wdata = mux_wdata;
  assign bus.mem_we    = |(gnt_q & bus.req & bus.we);
  assign bus.mem_re    = |(gnt_q & bus.req & ~bus.we);
  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.preempt   = preempt_q;
  assign bus.busy      = |gnt_q;

endmodule
